// File: rtl/cpu_pkg.sv
// Shared LEGv8 definitions: op enum, opcode/prefix constants, condition codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_B     = 4'd0,
        OP_BCOND = 4'd1,
        OP_BL    = 4'd2,
        OP_BR    = 4'd3,
        OP_CBZ   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ADDS  = 4'd6,
        OP_LDUR  = 4'd7,
        OP_STUR  = 4'd8,
        OP_SUBS  = 4'd9
    } op_e;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 26;

    // 11-bit opcodes for R/D/branch-register formats
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;

    // Shorter opcode prefixes for B/CB/I formats
    localparam logic [5:0] PFX_B     = 6'b000101;
    localparam logic [5:0] PFX_BL    = 6'b100101;
    localparam logic [7:0] PFX_BCOND = 8'b01010100;
    localparam logic [7:0] PFX_CBZ   = 8'b10110100;
    localparam logic [9:0] PFX_ADDI  = 10'b1001000100;

    // B.cond condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

endpackage

// File: rtl/legv8_instr_encode.sv
// Combinational LEGv8 encoder with immediate range check and illegal-op flag.
module legv8_instr_encode
    import cpu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [3:0]  cond_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic fits19;
    logic fits12u;
    logic fits9;

    // Immediate fits when the discarded upper bits are a pure sign (or zero) extension
    always_comb begin
        fits19  = (&imm_i[25:18]) | ~(|imm_i[25:18]);
        fits12u = ~(|imm_i[25:12]);
        fits9   = (&imm_i[25:8]) | ~(|imm_i[25:8]);
    end

    // Field packing per op; unknown ops produce a zero word and flag illegal
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_B:     word_o = {PFX_B, imm_i};
            OP_BL:    word_o = {PFX_BL, imm_i};
            OP_BCOND: begin
                word_o    = {PFX_BCOND, imm_i[18:0], 1'b0, cond_i};
                illegal_o = ~fits19;
            end
            OP_CBZ: begin
                word_o    = {PFX_CBZ, imm_i[18:0], rd_i};
                illegal_o = ~fits19;
            end
            OP_BR:    word_o = {OPC_BR, 11'd0, rn_i, 5'd0};
            OP_ADDI: begin
                word_o    = {PFX_ADDI, imm_i[11:0], rn_i, rd_i};
                illegal_o = ~fits12u;
            end
            OP_ADDS:  word_o = {OPC_ADDS, rm_i, 6'd0, rn_i, rd_i};
            OP_SUBS:  word_o = {OPC_SUBS, rm_i, 6'd0, rn_i, rd_i};
            OP_LDUR: begin
                word_o    = {OPC_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                illegal_o = ~fits9;
            end
            OP_STUR: begin
                word_o    = {OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                illegal_o = ~fits9;
            end
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Sequential program loader: accepts symbolic instructions, encodes them and
// writes words into instruction memory from address 0 upward.
module imem_program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [3:0]        cond,
    input  logic [25:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ENC  = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic              last_q;
    logic [3:0]        op_q;
    logic [4:0]        rd_q;
    logic [4:0]        rn_q;
    logic [4:0]        rm_q;
    logic [3:0]        cond_q;
    logic [25:0]       imm_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [CNT_W-1:0]  word_count_q;
    logic              done_q;
    logic              full_q;
    logic              err_q;

    logic [31:0]       wdata_d;
    logic              illegal_d;

    legv8_instr_encode u_enc (
        .op_i      (op_q),
        .rd_i      (rd_q),
        .rn_i      (rn_q),
        .rm_i      (rm_q),
        .cond_i    (cond_q),
        .imm_i     (imm_q),
        .word_o    (wdata_d),
        .illegal_o (illegal_d)
    );

    // Loader FSM: latch -> encode/check -> single-cycle write -> next or terminal
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            last_q       <= 1'b0;
            op_q         <= '0;
            rd_q         <= '0;
            rn_q         <= '0;
            rm_q         <= '0;
            cond_q       <= '0;
            imm_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        rd_q       <= rd;
                        rn_q       <= rn;
                        rm_q       <= rm;
                        cond_q     <= cond;
                        imm_q      <= imm;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    mem_wdata_q <= wdata_d;
                    if (illegal_d) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        mem_we_q <= 1'b1;
                        state_q  <= ST_WR;
                    end
                end
                ST_WR: begin
                    // Address wraps to 0 only on the write that fills memory
                    mem_addr_q   <= mem_addr_q + ADDR_W'(1);
                    word_count_q <= word_count_q + CNT_W'(1);
                    if (last_q || (mem_addr_q == ADDR_MAX)) begin
                        done_q  <= 1'b1;
                        full_q  <= (mem_addr_q == ADDR_MAX);
                        state_q <= ST_DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_DONE, ST_ERR: state_q <= state_q;
                default:         state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = in_ready_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        word_count = word_count_q;
        done       = done_q;
        full       = full_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader with a 4-word memory.
module tb_imem_program_loader;

    localparam int unsigned AW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [3:0]    op;
    logic [4:0]    rd;
    logic [4:0]    rn;
    logic [4:0]    rm;
    logic [3:0]    cond;
    logic [25:0]   imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          done;
    logic          full;
    logic          err;

    imem_program_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .op         (op),
        .rd         (rd),
        .rn         (rn),
        .rm         (rm),
        .cond       (cond),
        .imm        (imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .done       (done),
        .full       (full),
        .err        (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    logic [AW-1:0] wr_ptr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        wr_ptr = '0;
    endtask

    task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                        input logic [4:0] m, input logic [3:0] c, input logic [25:0] im,
                        input logic l, input bit exp_wr, input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
            return;
        end
        op = o; rd = d; rn = n; rm = m; cond = c; imm = im; in_last = l;
        in_valid = 1'b1;
        if (exp_wr) begin
            sb_q.push_back('{addr: wr_ptr, data: w, cyc: cyc + 2});
            wr_ptr = wr_ptr + AW'(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic hold_valid(input int n);
        @(negedge clk);
        op = 4'd5; rd = 5'd1; rn = 5'd1; imm = 26'd1;
        in_valid = 1'b1;
        idle(n);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op = '0; rd = '0; rn = '0; rm = '0; cond = '0; imm = '0;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // ADDI x1, x2, #5
        send(4'd5, 5'd1, 5'd2, 5'd0, 4'd0, 26'd5, 1'b0, 1'b1, 32'h91001441);
        idle(3);
        check("addi_word_count", 32'(word_count), 32'd1);
        check("addi_mem_addr", 32'(mem_addr), 32'd1);
        check("addi_in_ready", 32'(in_ready), 32'd1);

        // B #-1, then ADDS x3, x1, x2 as last
        do_reset();
        send(4'd0, 5'd0, 5'd0, 5'd0, 4'd0, 26'h3FFFFFF, 1'b0, 1'b1, 32'h17FFFFFF);
        send(4'd6, 5'd3, 5'd1, 5'd2, 4'd0, 26'd0, 1'b1, 1'b1, 32'hAB020023);
        idle(3);
        check("last_done", 32'(done), 32'd1);
        check("last_in_ready", 32'(in_ready), 32'd0);
        check("last_full", 32'(full), 32'd0);
        check("last_word_count", 32'(word_count), 32'd2);
        hold_valid(5);
        check("done_held", 32'(done), 32'd1);

        // LDUR / STUR with negative offset
        do_reset();
        send(4'd7, 5'd4, 5'd5, 5'd0, 4'd0, 26'h3FFFFF8, 1'b0, 1'b1, 32'hF85F80A4);
        send(4'd8, 5'd4, 5'd5, 5'd0, 4'd0, 26'h3FFFFF8, 1'b1, 1'b1, 32'hF81F80A4);
        idle(3);
        check("ldst_done", 32'(done), 32'd1);

        // Range / op errors
        do_reset();
        send(4'd4, 5'd0, 5'd0, 5'd0, 4'd0, 26'h0040000, 1'b0, 1'b0, 32'd0);
        idle(3);
        check("cbz_err", 32'(err), 32'd1);
        check("cbz_in_ready", 32'(in_ready), 32'd0);
        check("cbz_word_count", 32'(word_count), 32'd0);
        check("cbz_done", 32'(done), 32'd0);
        do_reset();
        send(4'd5, 5'd1, 5'd2, 5'd0, 4'd0, 26'h0001000, 1'b0, 1'b0, 32'd0);
        idle(3);
        check("addi_range_err", 32'(err), 32'd1);
        check("addi_range_addr", 32'(mem_addr), 32'd0);
        do_reset();
        send(4'd12, 5'd1, 5'd2, 5'd3, 4'd0, 26'd0, 1'b0, 1'b0, 32'd0);
        idle(3);
        check("bad_op_err", 32'(err), 32'd1);
        hold_valid(4);
        check("err_held", 32'(err), 32'd1);

        // Range boundaries that must pass; fills the 4-word memory
        do_reset();
        send(4'd1, 5'd0, 5'd0, 5'd0, 4'hC, 26'h3FC0000, 1'b0, 1'b1, 32'h5480000C);
        send(4'd4, 5'd7, 5'd0, 5'd0, 4'd0, 26'h003FFFF, 1'b0, 1'b1, 32'hB47FFFE7);
        send(4'd5, 5'd0, 5'd31, 5'd0, 4'd0, 26'h0000FFF, 1'b0, 1'b1, 32'h913FFFE0);
        send(4'd7, 5'd0, 5'd0, 5'd0, 4'd0, 26'h00000FF, 1'b0, 1'b1, 32'hF84FF000);
        idle(3);
        check("full1_full", 32'(full), 32'd1);
        check("full1_done", 32'(done), 32'd1);
        check("full1_word_count", 32'(word_count), 32'd4);
        check("full1_mem_addr", 32'(mem_addr), 32'd0);
        check("full1_err", 32'(err), 32'd0);
        hold_valid(5);
        check("full1_in_ready", 32'(in_ready), 32'd0);
        check("full1_count_held", 32'(word_count), 32'd4);

        // Register-format ops, also filling memory
        do_reset();
        send(4'd3, 5'd0, 5'd30, 5'd0, 4'd0, 26'd0, 1'b0, 1'b1, 32'hD60003C0);
        send(4'd2, 5'd0, 5'd0, 5'd0, 4'd0, 26'd1, 1'b0, 1'b1, 32'h94000001);
        send(4'd9, 5'd31, 5'd0, 5'd31, 4'd0, 26'd0, 1'b0, 1'b1, 32'hEB1F001F);
        send(4'd5, 5'd1, 5'd2, 5'd0, 4'd0, 26'd5, 1'b0, 1'b1, 32'h91001441);
        idle(3);
        check("full2_full", 32'(full), 32'd1);
        check("full2_word_count", 32'(word_count), 32'd4);

        // Reset during ENC of the second instruction
        do_reset();
        send(4'd5, 5'd1, 5'd2, 5'd0, 4'd0, 26'd5, 1'b0, 1'b1, 32'h91001441);
        send(4'd5, 5'd2, 5'd3, 5'd0, 4'd0, 26'd6, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        rst    = 1'b1;
        wr_ptr = '0;
        send(4'd5, 5'd1, 5'd2, 5'd0, 4'd0, 26'd5, 1'b0, 1'b1, 32'h91001441);
        idle(3);
        check("reload_word_count", 32'(word_count), 32'd1);

        idle(4);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
